// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// FSM states, requester IDs, default timeout and bus width.
package mem_arb_pkg;

  localparam int unsigned BUS_W       = 32;
  localparam int          TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of fetch port, data port and memory-side bus signals.
// slave: arbiter view; master: requester/memory/bench view.
interface mem_bus_arbiter_if;
  import mem_arb_pkg::*;

  logic             if_req;
  logic [BUS_W-1:0] if_addr;
  logic [BUS_W-1:0] if_data;
  logic             if_ack;

  logic             d_req;
  logic             d_we;
  logic [3:0]       d_wstrb;
  logic [BUS_W-1:0] d_addr;
  logic [BUS_W-1:0] d_wdata;
  logic [BUS_W-1:0] d_rdata;
  logic             d_ack;

  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_wstrb;
  logic [BUS_W-1:0] mem_addr;
  logic [BUS_W-1:0] mem_wdata;
  logic [BUS_W-1:0] mem_rdata;
  logic             mem_ack;

  logic             bus_error;
  logic [BUS_W-1:0] error_addr;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_wstrb, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_data, if_ack, d_rdata, d_ack,
    output mem_req, mem_we, mem_wstrb,
    output mem_addr, mem_wdata,
    output bus_error, error_addr
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_wstrb, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_data, if_ack, d_rdata, d_ack,
    input  mem_req, mem_we, mem_wstrb,
    input  mem_addr, mem_wdata,
    input  bus_error, error_addr
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_pick2.sv
// Two-way combinational grant pick (fetch vs data).
// Ports: i_if_req, i_d_req, i_last_grant -> o_grant_id, o_grant_valid.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic i_if_req,
  input  logic i_d_req,
  input  gnt_t i_last_grant,
  output gnt_t o_grant_id,
  output logic o_grant_valid
);

  logic w_both;
  logic w_tie_data;

  assign w_both = i_if_req & i_d_req;
  // Round-robin hands the tie to whoever did not win last.
  assign w_tie_data = (PRIO_MODE != 0) ||
                      (i_last_grant == GNT_FETCH);

  always_comb begin
    o_grant_id = GNT_FETCH;
    unique case (1'b1)
      w_both:
        o_grant_id = w_tie_data ? GNT_DATA : GNT_FETCH;
      (i_d_req && !i_if_req):
        o_grant_id = GNT_DATA;
      default:
        o_grant_id = GNT_FETCH;
    endcase
  end

  assign o_grant_valid = i_if_req | i_d_req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports, with timeout.
// Ports: clk, reset (sync, active-high), bus (slave modport).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  gnt_t             r_gnt;
  gnt_t             r_last;
  gnt_t             w_pick;
  logic             w_pick_vld;
  logic [15:0]      r_cnt;
  logic             w_start;
  logic             w_done;
  logic             w_tmo;

  logic             r_mem_req;
  logic             r_mem_we;
  logic [3:0]       r_mem_wstrb;
  logic [BUS_W-1:0] r_mem_addr;
  logic [BUS_W-1:0] r_mem_wdata;
  logic [BUS_W-1:0] r_if_data;
  logic [BUS_W-1:0] r_d_rdata;
  logic             r_bus_error;
  logic [BUS_W-1:0] r_error_addr;

  arb_pick2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .i_if_req      (bus.if_req),
    .i_d_req       (bus.d_req),
    .i_last_grant  (r_last),
    .o_grant_id    (w_pick),
    .o_grant_valid (w_pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // mem_ack takes precedence over an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_start     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt        <= GNT_FETCH;
      r_last       <= GNT_DATA;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_data    <= '0;
      r_d_rdata    <= '0;
      r_bus_error  <= 1'b0;
      r_error_addr <= '0;
    end else begin
      if (r_state == WAIT) r_cnt <= r_cnt + 16'd1;
      if (w_start) begin
        r_gnt     <= w_pick;
        r_cnt     <= '0;
        r_mem_req <= 1'b1;
        if (w_pick == GNT_DATA) begin
          r_mem_we    <= bus.d_we;
          r_mem_wstrb <= bus.d_we ? bus.d_wstrb : 4'b0000;
          r_mem_addr  <= bus.d_addr;
          r_mem_wdata <= bus.d_wdata;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_wstrb <= 4'b0000;
          r_mem_addr  <= bus.if_addr;
          r_mem_wdata <= '0;
        end
      end
      // A timed-out read returns zero to its requester.
      if (w_done || w_tmo) begin
        r_mem_req <= 1'b0;
        if (r_gnt == GNT_FETCH)
          r_if_data <= w_done ? bus.mem_rdata : '0;
        else if (!r_mem_we)
          r_d_rdata <= w_done ? bus.mem_rdata : '0;
      end
      if (w_done) r_last <= r_gnt;
      if (w_tmo) begin
        r_bus_error <= 1'b1;
        if (!r_bus_error) r_error_addr <= r_mem_addr;
      end
    end
  end

  assign bus.if_ack     = (r_state == RESP) &&
                          (r_gnt == GNT_FETCH);
  assign bus.d_ack      = (r_state == RESP) &&
                          (r_gnt == GNT_DATA);
  assign bus.if_data    = r_if_data;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wstrb  = r_mem_wstrb;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.bus_error  = r_bus_error;
  assign bus.error_addr = r_error_addr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// u0: round-robin, TIMEOUT=4; u1: fixed data priority.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus0();
  mem_bus_arbiter_if bus1();

  mem_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT(4)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mem_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT(255)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic        e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_if;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[5];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    bus0.if_req = 0; bus0.if_addr = '0;
    bus0.d_req = 0; bus0.d_we = 0; bus0.d_wstrb = '0;
    bus0.d_addr = '0; bus0.d_wdata = '0;
    bus0.mem_rdata = '0; bus0.mem_ack = 0;
    bus1.if_req = 0; bus1.if_addr = '0;
    bus1.d_req = 0; bus1.d_we = 0; bus1.d_wstrb = '0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    bus1.mem_rdata = '0; bus1.mem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clr_in();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_req0();
    for (int t = 0; t < 10 && bus0.mem_req !== 1'b1; t++)
      @(negedge clk);
    chk("req0_seen", bus0.mem_req, 1);
  endtask

  task automatic wait_req1();
    for (int t = 0; t < 10 && bus1.mem_req !== 1'b1; t++)
      @(negedge clk);
    chk("req1_seen", bus1.mem_req, 1);
  endtask

  task automatic ack0(input logic [31:0] d);
    bus0.mem_ack = 1; bus0.mem_rdata = d;
    @(negedge clk);
    bus0.mem_ack = 0; bus0.mem_rdata = '0;
  endtask

  task automatic ack1(input logic [31:0] d);
    bus1.mem_ack = 1; bus1.mem_rdata = d;
    @(negedge clk);
    bus1.mem_ack = 0; bus1.mem_rdata = '0;
  endtask

  // Starts and ends at a negedge with u0 idle.
  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      bus0.d_req = 1; bus0.d_we = v.we;
      bus0.d_wstrb = v.wstrb; bus0.d_addr = v.addr;
      bus0.d_wdata = v.wdata;
    end else begin
      bus0.if_req = 1; bus0.if_addr = v.addr;
    end
    @(negedge clk);
    chk("v_mem_req", bus0.mem_req, 1);
    chk("v_mem_we", bus0.mem_we, v.e_we);
    chk("v_mem_wstrb", bus0.mem_wstrb, v.e_wstrb);
    chk("v_mem_addr", bus0.mem_addr, v.addr);
    if (v.e_we) chk("v_mem_wdata", bus0.mem_wdata, v.wdata);
    for (int i = 0; i < v.dly; i++) begin
      @(negedge clk);
      chk("v_hold", bus0.mem_req, 1);
    end
    ack0(v.rdata);
    bus0.if_req = 0; bus0.d_req = 0;
    chk("v_if_ack", bus0.if_ack, !v.is_d);
    chk("v_d_ack", bus0.d_ack, v.is_d);
    chk("v_req_drop", bus0.mem_req, 0);
    chk("v_if_data", bus0.if_data, v.e_if);
    chk("v_d_rdata", bus0.d_rdata, v.e_d);
    @(negedge clk);
    chk("v_ack_end", {bus0.if_ack, bus0.d_ack}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 4'h0, 32'h100, 32'h0,
               32'hDEADBEEF, 2, 1'b0, 4'h0,
               32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 4'h3, 32'h2000, 32'h12345678,
               32'hFFFFFFFF, 1, 1'b1, 4'h3,
               32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 4'hF, 32'h3004, 32'h0,
               32'hA5A55A5A, 0, 1'b0, 4'h0,
               32'hDEADBEEF, 32'hA5A55A5A};
    tbl[3] = '{1'b1, 1'b1, 4'hC, 32'h3008, 32'h0BADF00D,
               32'h77777777, 0, 1'b1, 4'hC,
               32'hDEADBEEF, 32'hA5A55A5A};
    // Ack arrives in the same cycle the timeout would fire.
    tbl[4] = '{1'b0, 1'b0, 4'h0, 32'h104, 32'h0,
               32'h13579BDF, 3, 1'b0, 4'h0,
               32'h13579BDF, 32'hA5A55A5A};

    clr_in();
    do_reset();
    chk("rst_mem_req", bus0.mem_req, 0);
    chk("rst_acks", {bus0.if_ack, bus0.d_ack}, 0);
    chk("rst_if_data", bus0.if_data, 0);
    chk("rst_d_rdata", bus0.d_rdata, 0);
    chk("rst_err", bus0.bus_error, 0);
    chk("rst_u1_req", bus1.mem_req, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Stray mem_ack while idle is ignored.
    ack0(32'hFFFF0000);
    chk("stray_ack", {bus0.if_ack, bus0.d_ack}, 0);
    chk("stray_data", bus0.if_data, 32'h13579BDF);

    // Round-robin with both ports held high.
    do_reset();
    bus0.if_req = 1; bus0.if_addr = 32'h300;
    bus0.d_req = 1; bus0.d_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      wait_req0();
      chk("rr_addr", bus0.mem_addr,
          (i % 2 == 0) ? 32'h300 : 32'h400);
      ack0(32'h50 + i);
      chk("rr_if_ack", bus0.if_ack, (i % 2 == 0));
      chk("rr_d_ack", bus0.d_ack, (i % 2 == 1));
      if (i == 3) begin
        bus0.if_req = 0; bus0.d_req = 0;
      end
      @(negedge clk);
      chk("rr_ack_1cyc", {bus0.if_ack, bus0.d_ack}, 0);
    end

    // Fixed priority: data keeps winning while held.
    do_reset();
    bus1.if_req = 1; bus1.if_addr = 32'h900;
    bus1.d_req = 1; bus1.d_addr = 32'hA00;
    for (int i = 0; i < 3; i++) begin
      wait_req1();
      chk("pr_data_addr", bus1.mem_addr, 32'hA00);
      ack1(32'h60 + i);
      chk("pr_d_ack", bus1.d_ack, 1);
      chk("pr_if_ack0", bus1.if_ack, 0);
      if (i == 2) bus1.d_req = 0;
      @(negedge clk);
    end
    wait_req1();
    chk("pr_fetch_addr", bus1.mem_addr, 32'h900);
    ack1(32'h0F0F0F0F);
    chk("pr_if_ack", bus1.if_ack, 1);
    chk("pr_if_data", bus1.if_data, 32'h0F0F0F0F);
    bus1.if_req = 0;
    @(negedge clk);

    // Timeout on u0 (TIMEOUT=4).
    do_reset();
    run_vec('{1'b0, 1'b0, 4'h0, 32'h60, 32'h0,
              32'hCAFEF00D, 0, 1'b0, 4'h0,
              32'hCAFEF00D, 32'h0});
    bus0.if_req = 1; bus0.if_addr = 32'h40;
    @(negedge clk);
    chk("to_req", bus0.mem_req, 1);
    repeat (3) @(negedge clk);
    chk("to_req_c4", bus0.mem_req, 1);
    chk("to_no_err_yet", bus0.bus_error, 0);
    @(negedge clk);
    bus0.if_req = 0;
    chk("to_req_drop", bus0.mem_req, 0);
    chk("to_if_ack", bus0.if_ack, 1);
    chk("to_if_data", bus0.if_data, 0);
    chk("to_err", bus0.bus_error, 1);
    chk("to_err_addr", bus0.error_addr, 32'h40);
    @(negedge clk);
    chk("to_ack_end", bus0.if_ack, 0);
    bus0.if_req = 1; bus0.if_addr = 32'h80;
    repeat (5) @(negedge clk);
    bus0.if_req = 0;
    chk("to2_if_ack", bus0.if_ack, 1);
    chk("to2_err", bus0.bus_error, 1);
    chk("to2_err_addr", bus0.error_addr, 32'h40);
    @(negedge clk);

    // Reset during WAIT.
    run_vec('{1'b0, 1'b0, 4'h0, 32'h500, 32'h0,
              32'h11112222, 0, 1'b0, 4'h0,
              32'h11112222, 32'h0});
    bus0.if_req = 1; bus0.if_addr = 32'h600;
    @(negedge clk);
    chk("mr_req", bus0.mem_req, 1);
    @(negedge clk);
    reset = 1;
    bus0.if_req = 0;
    @(negedge clk);
    reset = 0;
    chk("mr_req0", bus0.mem_req, 0);
    chk("mr_acks", {bus0.if_ack, bus0.d_ack}, 0);
    chk("mr_if_data", bus0.if_data, 0);
    chk("mr_err", bus0.bus_error, 0);
    chk("mr_err_addr", bus0.error_addr, 0);
    chk("mr_addr", bus0.mem_addr, 0);
    @(negedge clk);
    chk("mr_no_ack", {bus0.if_ack, bus0.d_ack}, 0);
    bus0.if_req = 1; bus0.if_addr = 32'h700;
    bus0.d_req = 1; bus0.d_addr = 32'h800;
    @(negedge clk);
    chk("mr_tie_addr", bus0.mem_addr, 32'h700);
    ack0(32'h3);
    bus0.if_req = 0; bus0.d_req = 0;
    chk("mr_tie_ack", bus0.if_ack, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
